button_conditioner: RTL and testbench

Front-end conditioning stage for the board's pushbuttons. Synchronises and debounces raw, active-low button pins and derives press, release and long-press pulses per button. Maintains the `reverse` direction level that drives the LED pattern sequencer directly downstream. All outputs are registered and glitch-free, so the sequencer can consume them without further filtering.

---
 rtl/board_pkg.sv | 19 +
 rtl/button_debounce.sv | 80 ++++++++
 rtl/button_conditioner.sv | 52 +++++
 tb/tb_button_conditioner.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared board constants and types for the button front end and the LED sequencer.
package board_pkg;

  localparam int DEBOUNCE_BITS_DEFAULT  = 18;
  localparam int LONG_BITS_DEFAULT      = 25;
  localparam int BTN_ACTIVE_LOW_DEFAULT = 1;

  // LED pattern sequencer timing, consumed downstream of the button conditioner.
  localparam int LED_COUNT_DEFAULT      = 8;
  localparam int LED_STEP_BITS_DEFAULT  = 23;

  typedef struct packed {
    logic level;
    logic press;
    logic rls;
    logic long_p;
  } btn_evt_t;

endpackage

// File: rtl/button_debounce.sv
// Single button channel: polarity fix, 2-flop synchroniser, debounce window,
// registered press/release pulses and a saturating long-press hold counter.
module button_debounce
  import board_pkg::*;
#(
  parameter int DEBOUNCE_BITS  = DEBOUNCE_BITS_DEFAULT,
  parameter int LONG_BITS      = LONG_BITS_DEFAULT,
  parameter int BTN_ACTIVE_LOW = BTN_ACTIVE_LOW_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     btn_raw_i,
  output btn_evt_t evt_o
);

  localparam logic [LONG_BITS-1:0] HOLD_PRE = ~LONG_BITS'(1);

  logic                     pin_pressed;
  logic                     s1_q, s2_q;
  logic [DEBOUNCE_BITS-1:0] db_cnt_q, db_cnt_d;
  logic                     level_q, level_d;
  logic                     press_q, press_d;
  logic                     rls_q, rls_d;
  logic [LONG_BITS-1:0]     hold_q, hold_d;
  logic                     long_q, long_d;

  assign pin_pressed = (BTN_ACTIVE_LOW != 0) ? ~btn_raw_i : btn_raw_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
      rls_q    <= 1'b0;
      hold_q   <= '0;
      long_q   <= 1'b0;
    end else begin
      s1_q     <= pin_pressed;
      s2_q     <= s1_q;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      press_q  <= press_d;
      rls_q    <= rls_d;
      hold_q   <= hold_d;
      long_q   <= long_d;
    end
  end

  // Any return to the current level clears the count, so bounces restart the window.
  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    press_d  = 1'b0;
    rls_d    = 1'b0;
    if (s2_q != level_q) begin
      if (&db_cnt_q) begin
        level_d = s2_q;
        press_d = s2_q;
        rls_d   = ~s2_q;
      end else begin
        db_cnt_d = db_cnt_q + DEBOUNCE_BITS'(1);
      end
    end
  end

  // Long pulse fires on the saturating step only, and not if the level drops on that edge.
  always_comb begin
    hold_d = '0;
    long_d = 1'b0;
    if (level_q) begin
      hold_d = (&hold_q) ? hold_q : hold_q + LONG_BITS'(1);
      long_d = (hold_q == HOLD_PRE) && level_d;
    end
  end

  assign evt_o = '{level: level_q, press: press_q, rls: rls_q, long_p: long_q};

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel pushbutton conditioner; channel 0 presses toggle the reverse level.
module button_conditioner
  import board_pkg::*;
#(
  parameter int NUM_BTN        = 2,
  parameter int DEBOUNCE_BITS  = DEBOUNCE_BITS_DEFAULT,
  parameter int LONG_BITS      = LONG_BITS_DEFAULT,
  parameter int BTN_ACTIVE_LOW = BTN_ACTIVE_LOW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long,
  output logic               reverse
);

  btn_evt_t evt [NUM_BTN];
  logic     reverse_q, reverse_d;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    button_debounce #(
      .DEBOUNCE_BITS (DEBOUNCE_BITS),
      .LONG_BITS     (LONG_BITS),
      .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
    ) u_db (
      .clk      (clk),
      .rst      (rst),
      .btn_raw_i(btn_raw[g]),
      .evt_o    (evt[g])
    );
    assign btn_level[g]   = evt[g].level;
    assign btn_press[g]   = evt[g].press;
    assign btn_release[g] = evt[g].rls;
    assign btn_long[g]    = evt[g].long_p;
  end

  always_comb begin
    reverse_d = reverse_q;
    if (btn_press[0]) reverse_d = ~reverse_q;
  end

  always_ff @(posedge clk) begin
    if (rst) reverse_q <= 1'b0;
    else     reverse_q <= reverse_d;
  end

  assign reverse = reverse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboarded bench: each scenario queues the pulses it expects with their cycle stamps.
module tb_button_conditioner;

  localparam int DB       = 4;
  localparam int LB       = 6;
  localparam int LAT      = (1 << DB) + 2;
  localparam int LONG_LAT = (1 << LB) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_raw;
  logic [1:0] btn_level, btn_press, btn_release, btn_long;
  logic       reverse;

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rls;
    logic [1:0] lng;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  logic exp_rev;

  button_conditioner #(
    .NUM_BTN       (2),
    .DEBOUNCE_BITS (DB),
    .LONG_BITS     (LB),
    .BTN_ACTIVE_LOW(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long),
    .reverse    (reverse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse cycle must match the head of the expectation queue.
  always @(negedge clk) begin
    if ((|{btn_press, btn_release, btn_long}) === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b long=%b",
                 cyc, btn_press, btn_release, btn_long);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc !== mon_e.cyc || btn_press !== mon_e.press ||
            btn_release !== mon_e.rls || btn_long !== mon_e.lng) begin
          errors++;
          $display("FAIL pulse got cyc=%0d p=%b r=%b l=%b expected cyc=%0d p=%b r=%b l=%b",
                   cyc, btn_press, btn_release, btn_long,
                   mon_e.cyc, mon_e.press, mon_e.rls, mon_e.lng);
        end
      end
    end
  end

  task automatic push_exp(input int c, input logic [1:0] p, input logic [1:0] r,
                          input logic [1:0] l);
    exp_t e;
    e = '{cyc: c, press: p, rls: r, lng: l};
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_raw = 2'b11;
    repeat (3) @(negedge clk);
    checks++;
    if ({btn_level, btn_press, btn_release, btn_long, reverse} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 0",
               {btn_level, btn_press, btn_release, btn_long, reverse});
    end
    rst = 1'b0;
    exp_rev = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if ({btn_level, reverse} !== 3'b0) begin
      errors++;
      $display("FAIL idle_after_reset got level=%b rev=%b expected 0", btn_level, reverse);
    end
  endtask

  task automatic test_clean_press();
    int t0;
    btn_raw[0] = 1'b0;
    t0 = cyc;
    push_exp(t0 + LAT, 2'b01, 2'b00, 2'b00);
    repeat (LAT) @(negedge clk);
    checks++;
    if (btn_level[0] !== 1'b1) begin
      errors++;
      $display("FAIL clean_level got %b expected 1", btn_level[0]);
    end
    checks++;
    if (reverse !== exp_rev) begin
      errors++;
      $display("FAIL rev_before_toggle got %b expected %b", reverse, exp_rev);
    end
    exp_rev = ~exp_rev;
    @(negedge clk);
    checks++;
    if (reverse !== exp_rev) begin
      errors++;
      $display("FAIL rev_after_press got %b expected %b", reverse, exp_rev);
    end
    repeat (10) @(negedge clk);
    btn_raw[0] = 1'b1;
    t0 = cyc;
    push_exp(t0 + LAT, 2'b00, 2'b01, 2'b00);
    repeat (LAT + 2) @(negedge clk);
    checks++;
    if (btn_level[0] !== 1'b0 || reverse !== exp_rev) begin
      errors++;
      $display("FAIL clean_release got level=%b rev=%b expected 0 %b",
               btn_level[0], reverse, exp_rev);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL clean_missing got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_bounce();
    int t0;
    for (int i = 0; i < 12; i++) begin
      btn_raw[0] = ~btn_raw[0];
      repeat (5) @(negedge clk);
    end
    btn_raw[0] = 1'b0;
    t0 = cyc;
    push_exp(t0 + LAT, 2'b01, 2'b00, 2'b00);
    repeat (LAT) @(negedge clk);
    checks++;
    if (btn_level[0] !== 1'b1) begin
      errors++;
      $display("FAIL bounce_level got %b expected 1", btn_level[0]);
    end
    exp_rev = ~exp_rev;
    @(negedge clk);
    checks++;
    if (reverse !== exp_rev) begin
      errors++;
      $display("FAIL bounce_rev got %b expected %b", reverse, exp_rev);
    end
    btn_raw[0] = 1'b1;
    t0 = cyc;
    push_exp(t0 + LAT, 2'b00, 2'b01, 2'b00);
    repeat (LAT + 2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bounce_missing got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_long_press();
    int t0;
    btn_raw[1] = 1'b0;
    t0 = cyc;
    push_exp(t0 + LAT, 2'b10, 2'b00, 2'b00);
    push_exp(t0 + LAT + LONG_LAT, 2'b00, 2'b00, 2'b10);
    repeat (100) @(negedge clk);
    btn_raw[1] = 1'b1;
    t0 = cyc;
    push_exp(t0 + LAT, 2'b00, 2'b10, 2'b00);
    repeat (LAT + 2) @(negedge clk);
    // Short hold: release well before the threshold, no long pulse.
    btn_raw[1] = 1'b0;
    t0 = cyc;
    push_exp(t0 + LAT, 2'b10, 2'b00, 2'b00);
    repeat (50) @(negedge clk);
    btn_raw[1] = 1'b1;
    t0 = cyc;
    push_exp(t0 + LAT, 2'b00, 2'b10, 2'b00);
    repeat (LAT + 80) @(negedge clk);
    checks++;
    if (reverse !== exp_rev) begin
      errors++;
      $display("FAIL long_rev got %b expected %b", reverse, exp_rev);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL long_missing got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_simultaneous();
    int t0;
    btn_raw = 2'b00;
    t0 = cyc;
    push_exp(t0 + LAT, 2'b11, 2'b00, 2'b00);
    repeat (LAT) @(negedge clk);
    checks++;
    if (btn_level !== 2'b11) begin
      errors++;
      $display("FAIL simul_level got %b expected 11", btn_level);
    end
    exp_rev = ~exp_rev;
    @(negedge clk);
    checks++;
    if (reverse !== 1'b1 || reverse !== exp_rev) begin
      errors++;
      $display("FAIL simul_rev got %b expected 1", reverse);
    end
    btn_raw = 2'b11;
    t0 = cyc;
    push_exp(t0 + LAT, 2'b00, 2'b11, 2'b00);
    repeat (LAT + 2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      btn_raw[0] = 1'b0;
      t0 = cyc;
      push_exp(t0 + LAT, 2'b01, 2'b00, 2'b00);
      repeat (LAT + 1) @(negedge clk);
      exp_rev = ~exp_rev;
      checks++;
      if (reverse !== exp_rev) begin
        errors++;
        $display("FAIL rev_seq%0d got %b expected %b", k, reverse, exp_rev);
      end
      btn_raw[0] = 1'b1;
      t0 = cyc;
      push_exp(t0 + LAT, 2'b00, 2'b01, 2'b00);
      repeat (LAT + 2) @(negedge clk);
    end
    btn_raw[1] = 1'b0;
    t0 = cyc;
    push_exp(t0 + LAT, 2'b10, 2'b00, 2'b00);
    repeat (LAT + 2) @(negedge clk);
    checks++;
    if (reverse !== exp_rev) begin
      errors++;
      $display("FAIL ch1_no_rev got %b expected %b", reverse, exp_rev);
    end
    btn_raw[1] = 1'b1;
    t0 = cyc;
    push_exp(t0 + LAT, 2'b00, 2'b10, 2'b00);
    repeat (LAT + 2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL simul_missing got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    btn_raw[1] = 1'b0;
    t0 = cyc;
    push_exp(t0 + LAT, 2'b10, 2'b00, 2'b00);
    repeat (LAT + 30) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({btn_level, btn_press, btn_release, btn_long, reverse} !== 9'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %b expected 0",
               {btn_level, btn_press, btn_release, btn_long, reverse});
    end
    exp_rev = 1'b0;
    rst = 1'b0;
    t0 = cyc;
    push_exp(t0 + LAT, 2'b10, 2'b00, 2'b00);
    repeat (LAT) @(negedge clk);
    checks++;
    if (btn_level[1] !== 1'b1) begin
      errors++;
      $display("FAIL mid_repress_level got %b expected 1", btn_level[1]);
    end
    repeat (25) @(negedge clk);
    btn_raw[1] = 1'b1;
    t0 = cyc;
    push_exp(t0 + LAT, 2'b00, 2'b10, 2'b00);
    repeat (LAT + 2) @(negedge clk);
    checks++;
    if (reverse !== exp_rev) begin
      errors++;
      $display("FAIL mid_rev got %b expected %b", reverse, exp_rev);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_missing got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    btn_raw = 2'b11;
    exp_rev = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
